// File: rtl/nibble_frame_serializer_pkg.sv
// Shared definitions for the nibble serializer and the downstream sorted-pair
// detector: frame width, default filler frame and the bit-index type, so both
// ends agree on frame layout and on what an idle frame looks like.
package nibble_frame_serializer_pkg;

  localparam int unsigned FRAME_W = 4;

  typedef logic [FRAME_W-1:0] frame_t;
  typedef logic [1:0]         bit_idx_t;

  // Descending pair (2,0): never a valid sorted pair, so the detector ignores it.
  localparam frame_t FILL_FRAME = 4'b1000;

  // Index of the last bit of a frame; the shifter reloads on this edge.
  localparam bit_idx_t LOAD_IDX = 2'd3;

endpackage

// File: rtl/nibble_sync_fifo.sv
// Synchronous FIFO of 4-bit frames.
// Ports:
//   clk, rst          clock, synchronous active-high flush
//   push, push_data   write request / frame (ignored when full)
//   pop, pop_data     read request (ignored when empty) / head frame
//   full, empty       registered occupancy flags
//   level             number of queued frames (0..DEPTH)
module nibble_sync_fifo
  import nibble_frame_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  frame_t                   push_data,
  input  logic                     pop,
  output frame_t                   pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  frame_t             mem_q [DEPTH];
  frame_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q,  level_d;
  logic               push_ok,  pop_ok;

  assign full     = (level_q == FULL_LVL);
  assign empty    = (level_q == '0);
  assign level    = level_q;
  assign pop_data = mem_q[rd_ptr_q];

  assign push_ok  = push & ~full;
  assign pop_ok   = pop  & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset: entries are only read when level says they are valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/nibble_frame_serializer.sv
// Serializes queued 4-bit frames MSB first onto a continuous 1-bit stream.
// One bit per clock; frames are aligned to reset release and repeat every
// 4 clocks. With nothing queued, the FILL frame is sent instead.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/in_data/in_ready   frame input handshake ([3:2] first value)
//   ser_out         serial bit (shreg MSB)
//   frame_start     ser_out carries bit 3 of a frame
//   frame_fill      current frame is FILL
//   fifo_level      queued frames
//   sent_count      data frames loaded into the shifter (wraps)
module nibble_frame_serializer
  import nibble_frame_serializer_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter frame_t      FILL  = FILL_FRAME,
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [FRAME_W-1:0]       in_data,
  output logic                     in_ready,
  output logic                     ser_out,
  output logic                     frame_start,
  output logic                     frame_fill,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         sent_count
);

  frame_t             shreg_q, shreg_d;
  bit_idx_t           bit_idx_q, bit_idx_d;
  logic               fill_q, fill_d;
  logic [CNT_W-1:0]   sent_count_q, sent_count_d;

  logic               fifo_full, fifo_empty;
  frame_t             fifo_head;
  logic               push, pop, load;

  // Ready comes from the registered level only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready = ~fifo_full;
  assign push     = in_valid & in_ready;
  assign load     = (bit_idx_q == LOAD_IDX);
  assign pop      = load & ~fifo_empty;

  nibble_sync_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    bit_idx_d    = bit_idx_q + 1'b1;   // 3 wraps to 0 on the load edge
    shreg_d      = {shreg_q[FRAME_W-2:0], 1'b0};
    fill_d       = fill_q;
    sent_count_d = sent_count_q;
    if (load) begin
      if (!fifo_empty) begin
        shreg_d      = fifo_head;
        fill_d       = 1'b0;
        sent_count_d = sent_count_q + 1'b1;
      end else begin
        shreg_d = FILL;
        fill_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q      <= FILL;
      bit_idx_q    <= '0;
      fill_q       <= 1'b1;
      sent_count_q <= '0;
    end else begin
      shreg_q      <= shreg_d;
      bit_idx_q    <= bit_idx_d;
      fill_q       <= fill_d;
      sent_count_q <= sent_count_d;
    end
  end

  assign ser_out     = shreg_q[FRAME_W-1];
  assign frame_start = (bit_idx_q == '0);
  assign frame_fill  = fill_q;
  assign sent_count  = sent_count_q;

endmodule
